// File: rtl/cla_pipe_addsub_if.sv
// Streaming bus for the pipelined CLA adder/subtractor.
// Carries the operand beat (upstream side) and the result beat (downstream side).
//
// Handshake rules, identical on both sides: a beat moves on a rising edge where
// valid and ready are both high. The sender holds valid and its payload steady
// until that edge. Ready may depend combinationally on the receiver's state but
// never on valid from the same side.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // The arithmetic unit.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit CLA slice is resolved per stage; the carry between slices is
// registered. Subtraction inverts b and the borrow-in when the beat enters, so
// every stage after the entry register is a plain adder slice.
// The whole pipe advances together: a full output register that is not being
// consumed stalls every stage (bubbles are kept, not squeezed out).
// WIDTH must be a multiple of BLOCK, and BLOCK a multiple of 4.
module cla_pipe_addsub #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  cla_pipe_addsub_if.slave    bus
);

  localparam int STAGES = WIDTH / BLOCK;
  localparam int NGRP   = BLOCK / 4;
  localparam int LAST   = STAGES - 1;

  // Full CLA over one BLOCK slice: 4-bit group propagate/generate, lookahead
  // across groups, then bit carries inside each group.
  // Returns {carry out of slice, carry into slice MSB, slice sum}.
  function automatic logic [BLOCK+1:0] cla_block(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP:0]    gc;
    logic             term;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Group carries as flat sum-of-products (no ripple between groups).
    gc[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    c[BLOCK] = gc[NGRP];
    return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
  endfunction

  // Per-stage beat state: operands (b already inverted for subtract), sum bits
  // resolved so far, and the carry into this stage's slice.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [BLOCK+1:0]  res   [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];

  logic              out_valid_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;
  logic              advance;

  assign advance       = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Resolve each stage's slice and merge it into that beat's partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res[k]   = cla_block(a_q[k][k*BLOCK +: BLOCK], b_q[k][k*BLOCK +: BLOCK], c_q[k]);
      nxt_s[k] = s_q[k];
      nxt_s[k][k*BLOCK +: BLOCK] = res[k][BLOCK-1:0];
    end
  end

  // Pipeline and output registers; everything holds while the pipe is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      c_q         <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      v_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        a_q[0] <= bus.a;
        b_q[0] <= bus.sub ? ~bus.b : bus.b;
        c_q[0] <= bus.cin ^ bus.sub;
        s_q[0] <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          s_q[k] <= nxt_s[k-1];
          c_q[k] <= res[k-1][BLOCK+1];
        end
      end
      out_valid_q <= v_q[LAST];
      if (v_q[LAST]) begin
        sum_q  <= nxt_s[LAST];
        cout_q <= res[LAST][BLOCK+1];
        ovf_q  <= res[LAST][BLOCK+1] ^ res[LAST][BLOCK];
        zero_q <= (nxt_s[LAST] == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: default 64/16 instance for directed scenarios,
// plus 32/8 and 16/16 instances for randomized streams with random back-pressure.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cla_pipe_addsub_if #(.WIDTH(64)) b64();
  cla_pipe_addsub_if #(.WIDTH(32)) b32();
  cla_pipe_addsub_if #(.WIDTH(16)) b16();

  cla_pipe_addsub #(.WIDTH(64), .BLOCK(16)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8))  dut32 (.clk(clk), .rst(rst), .bus(b32));
  cla_pipe_addsub #(.WIDTH(16), .BLOCK(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  // ---------------- reference model ----------------
  // Returns {cout, ovf, zero, sum zero-extended to 64 bits}.
  function automatic logic [66:0] ref_model(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic cin,
                                            input logic sub);
    logic [63:0] mask, aa, bb, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + 65'(cin ^ sub);
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {co, ov, (s == 64'd0), s};
  endfunction

  // ---------------- scoreboards ----------------
  logic [66:0] exp_q64[$];
  logic [66:0] exp_q32[$];
  logic [66:0] exp_q16[$];
  int          acc_q64[$];
  int          acc_q32[$];
  int          acc_q16[$];
  bit          lat_q64[$];
  bit          lat_q32[$];
  bit          lat_q16[$];

  bit          seen64 = 0, seen32 = 0, seen16 = 0;
  int          first64 = 0, first32 = 0, first16 = 0;
  bit          hold64 = 0;
  logic [66:0] hold_val64 = '0;
  bit          rand_rdy32 = 0, rand_rdy16 = 0;

  // 64-bit monitor: pops on consume, checks latency and stall stability.
  always @(negedge clk) begin
    logic [66:0] got, ev;
    int          acc;
    bit          lat;
    if (rst) begin
      got = {b64.cout, b64.ovf, b64.zero, b64.sum};
      if (b64.out_valid) begin
        if (!seen64) begin seen64 = 1; first64 = cyc; end
        if (hold64) begin
          checks++;
          if (got !== hold_val64) begin
            errors++;
            $display("FAIL stall_hold64 got %h want %h", got, hold_val64);
          end
        end
        if (b64.out_ready) begin
          checks++;
          if (exp_q64.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out64 got %h want none", got);
          end else begin
            ev  = exp_q64.pop_front();
            acc = acc_q64.pop_front();
            lat = lat_q64.pop_front();
            if (got !== ev) begin
              errors++;
              $display("FAIL result64 got %h want %h", got, ev);
            end
            if (lat) begin
              checks++;
              if (first64 - acc !== 4) begin
                errors++;
                $display("FAIL latency64 got %0d want 4", first64 - acc);
              end
            end
          end
          seen64 = 0;
          hold64 = 0;
        end else begin
          hold64     = 1;
          hold_val64 = got;
        end
      end else begin
        if (hold64) begin
          checks++;
          errors++;
          $display("FAIL stall_drop64 got out_valid 0 want 1");
        end
        hold64 = 0;
      end
    end
  end

  // 32-bit monitor.
  always @(negedge clk) begin
    logic [66:0] got, ev;
    int          acc;
    bit          lat;
    if (rst && b32.out_valid) begin
      got = {b32.cout, b32.ovf, b32.zero, 32'd0, b32.sum};
      if (!seen32) begin seen32 = 1; first32 = cyc; end
      if (b32.out_ready) begin
        checks++;
        if (exp_q32.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out32 got %h want none", got);
        end else begin
          ev  = exp_q32.pop_front();
          acc = acc_q32.pop_front();
          lat = lat_q32.pop_front();
          if (got !== ev) begin
            errors++;
            $display("FAIL result32 got %h want %h", got, ev);
          end
          if (lat) begin
            checks++;
            if (first32 - acc !== 4) begin
              errors++;
              $display("FAIL latency32 got %0d want 4", first32 - acc);
            end
          end
        end
        seen32 = 0;
      end
    end
  end

  // 16-bit monitor.
  always @(negedge clk) begin
    logic [66:0] got, ev;
    int          acc;
    bit          lat;
    if (rst && b16.out_valid) begin
      got = {b16.cout, b16.ovf, b16.zero, 48'd0, b16.sum};
      if (!seen16) begin seen16 = 1; first16 = cyc; end
      if (b16.out_ready) begin
        checks++;
        if (exp_q16.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out16 got %h want none", got);
        end else begin
          ev  = exp_q16.pop_front();
          acc = acc_q16.pop_front();
          lat = lat_q16.pop_front();
          if (got !== ev) begin
            errors++;
            $display("FAIL result16 got %h want %h", got, ev);
          end
          if (lat) begin
            checks++;
            if (first16 - acc !== 1) begin
              errors++;
              $display("FAIL latency16 got %0d want 1", first16 - acc);
            end
          end
        end
        seen16 = 0;
      end
    end
  end

  // Random back-pressure for the sweep instances.
  always @(posedge clk) begin
    if (rand_rdy32) begin #1; b32.out_ready = 1'($urandom_range(0, 1)); end
  end
  always @(posedge clk) begin
    if (rand_rdy16) begin #1; b16.out_ready = 1'($urandom_range(0, 1)); end
  end

  // ---------------- driver tasks ----------------
  task automatic send64(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input bit lat);
    int t = 0;
    b64.in_valid = 1'b1; b64.a = a; b64.b = b; b64.cin = cin; b64.sub = sub;
    @(negedge clk);
    while (!b64.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!b64.in_ready) begin
      checks++; errors++;
      $display("FAIL send64_timeout got in_ready 0 want 1");
    end else begin
      exp_q64.push_back(ref_model(64, a, b, cin, sub));
      acc_q64.push_back(cyc + 1);
      lat_q64.push_back(lat);
    end
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input bit lat);
    int t = 0;
    b32.in_valid = 1'b1; b32.a = a; b32.b = b; b32.cin = cin; b32.sub = sub;
    @(negedge clk);
    while (!b32.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!b32.in_ready) begin
      checks++; errors++;
      $display("FAIL send32_timeout got in_ready 0 want 1");
    end else begin
      exp_q32.push_back(ref_model(32, {32'd0, a}, {32'd0, b}, cin, sub));
      acc_q32.push_back(cyc + 1);
      lat_q32.push_back(lat);
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input bit lat);
    int t = 0;
    b16.in_valid = 1'b1; b16.a = a; b16.b = b; b16.cin = cin; b16.sub = sub;
    @(negedge clk);
    while (!b16.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!b16.in_ready) begin
      checks++; errors++;
      $display("FAIL send16_timeout got in_ready 0 want 1");
    end else begin
      exp_q16.push_back(ref_model(16, {48'd0, a}, {48'd0, b}, cin, sub));
      acc_q16.push_back(cyc + 1);
      lat_q16.push_back(lat);
    end
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int t = 0;
    int left;
    left = (which == 64) ? exp_q64.size() : (which == 32) ? exp_q32.size() : exp_q16.size();
    while (left != 0 && t < 100) begin
      @(posedge clk); t++;
      left = (which == 64) ? exp_q64.size() : (which == 32) ? exp_q32.size() : exp_q16.size();
    end
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL drain%0d got %0d pending want 0", which, left);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b64.out_valid); end
    checks++; if (b64.sum !== 64'd0)      begin errors++; $display("FAIL rst_sum got %h want 0", b64.sum); end
    checks++; if (b64.cout !== 1'b0)      begin errors++; $display("FAIL rst_cout got %b want 0", b64.cout); end
    checks++; if (b64.ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf got %b want 0", b64.ovf); end
    checks++; if (b64.zero !== 1'b0)      begin errors++; $display("FAIL rst_zero got %b want 0", b64.zero); end
    rst = 1'b1;
    #1;
    checks++; if (b64.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b want 1", b64.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send64(64'd2, 64'd5, 1'b0, 1'b0, 1);
    send64(64'd2232300, 64'd9890809, 1'b1, 1'b0, 1);
    drain(64);
  endtask

  task automatic test_sub();
    send64(64'd5, 64'd2, 1'b0, 1'b1, 1);
    send64(64'd2, 64'd5, 1'b0, 1'b1, 1);
    send64(64'd9, 64'd4, 1'b1, 1'b1, 1);
    drain(64);
  endtask

  task automatic test_wrap_flags();
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1);
    send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1);
    send64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1);
    send64(64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0001, 1'b0, 1'b0, 1);
    drain(64);
  endtask

  task automatic test_back_pressure();
    int t = 0;
    b64.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send64(64'(i), 64'(10 * i), 1'b0, 1'b0, 0);
      end
      begin
        while (!b64.out_valid && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (!b64.out_valid) begin
          errors++;
          $display("FAIL bp_first_result got out_valid 0 want 1");
        end
        b64.out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          checks++;
          if (b64.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 0", b64.in_ready);
          end
        end
        @(posedge clk); #1;
        b64.out_ready = 1'b1;
      end
    join
    drain(64);
  endtask

  task automatic test_reset_midflight();
    b64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send64(64'(100 + i), 64'd1, 1'b0, 1'b0, 0);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", b64.out_valid); end
    checks++; if (b64.sum !== 64'd0)      begin errors++; $display("FAIL midrst_sum got %h want 0", b64.sum); end
    rst = 1'b1;
    exp_q64.delete(); acc_q64.delete(); lat_q64.delete();
    seen64 = 0; hold64 = 0;
    repeat (8) @(posedge clk);
    #1;
    send64(64'd1, 64'd1, 1'b0, 1'b0, 1);
    drain(64);
  endtask

  task automatic test_sweep32();
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    drain(32);
    rand_rdy32 = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    rand_rdy32 = 0;
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    drain(32);
  endtask

  task automatic test_sweep16();
    b16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    drain(16);
    rand_rdy16 = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    rand_rdy16 = 0;
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    drain(16);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    b64.in_valid = 0; b64.a = '0; b64.b = '0; b64.cin = 0; b64.sub = 0; b64.out_ready = 1;
    b32.in_valid = 0; b32.a = '0; b32.b = '0; b32.cin = 0; b32.sub = 0; b32.out_ready = 1;
    b16.in_valid = 0; b16.a = '0; b16.b = '0; b16.cin = 0; b16.sub = 0; b16.out_ready = 1;
    test_reset();
    test_add();
    test_sub();
    test_wrap_flags();
    test_back_pressure();
    test_reset_midflight();
    test_sweep32();
    test_sweep16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
